led_sequencer: RTL
==================

LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter: BASE_DIV, default 25000000, clk cycles between steps at speed 0; legal range 8..2^27-1.
REQ-002 Parameter: PASSES, default 4, completed passes per mode before rotating; legal range 1..15.
REQ-003 Port: clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: en  input  1  run enable; low pauses sequencing.
REQ-006 Port: speed  input  2  step rate select; divisor = BASE_DIV >> speed.
REQ-007 Port: feedback  input  27  current LED pattern from datapath.
REQ-008 Port: mode_out  output  2  mode to control unit (01, 10, 11 only).
REQ-009 Port: en_dp  output  1  one-cycle datapath step pulse.
REQ-010 Port: dp_rst  output  1  one-cycle datapath/control-unit reset pulse.
REQ-011 Port: busy  output  1  high in LOAD, RUN, SWITCH.

Function
REQ-012 FSM states: IDLE, LOAD, RUN, SWITCH; all outputs registered.
REQ-013 IDLE: en_dp=0, dp_rst=0, counters hold; en=1 -> LOAD next cycle.
REQ-014 LOAD: dp_rst=1 for exactly one cycle, divider and pass counters cleared -> RUN.
REQ-015 RUN: 27-bit divider counts 0..divisor-1; at divisor-1, en_dp=1 for one cycle and divider returns to 0.
REQ-016 speed sampled only at divider wrap; mid-interval changes take effect on the following interval.
REQ-017 Home pattern = 27'h0000038; pass complete when, on a cycle following an en_dp pulse, feedback == home and an away flag is set.
REQ-018 Away flag set when feedback != home after an en_dp pulse; cleared on pass complete, LOAD, SWITCH.
REQ-019 Pass counter (4 bits) increments on pass complete; reaching PASSES -> SWITCH.
REQ-020 SWITCH: mode_out rotates 01 -> 10 -> 11 -> 01; dp_rst=1 for one cycle; counters, away flag cleared; en_dp=0 -> RUN.
REQ-021 en=0 in any state -> IDLE next cycle; same-cycle pass complete discarded; mode_out preserved.
REQ-022 en rising from IDLE always passes through LOAD (datapath restarts from home).
REQ-023 en_dp and dp_rst never high in the same cycle.
REQ-024 Minimum step interval = 1 cycle when divisor < 1 (clamped to 1).

Reset
REQ-025 rst=1 (any state, mid-step or mid-SWITCH): next edge state=IDLE, mode_out=2'b01, en_dp=0, dp_rst=0, busy=0, divider=0, pass counter=0, away flag=0.
REQ-026 rst has priority over en and all FSM transitions.

Configuration
REQ-027 Macro LED_SEQ_TIMEOUT_EN defined: 16-bit step watchdog counts en_dp pulses in RUN, cleared on pass complete/LOAD/SWITCH; reaching 65535 forces SWITCH regardless of pass count.
REQ-028 Macro LED_SEQ_TIMEOUT_EN undefined: no watchdog logic; rotation only via REQ-019.

Verification (BASE_DIV=8, PASSES=2)
REQ-029 rst 1 cycle, en=1 -> cycle+1 LOAD with dp_rst=1, mode_out=01, then en_dp every 8 cycles at speed 0.
REQ-030 speed=2 mid-interval -> current interval still 8 cycles, following intervals 2 cycles.
REQ-031 feedback driven home/away/home twice -> SWITCH, dp_rst pulse, mode_out 01->10; repeat -> 11 -> 01.
REQ-032 en=0 on same cycle as pass complete -> IDLE, pass count unchanged, mode_out held; en=1 -> LOAD, dp_rst pulse.
REQ-033 rst during SWITCH -> mode_out=01, all outputs 0, state IDLE.
REQ-034 LED_SEQ_TIMEOUT_EN defined, feedback stuck away -> SWITCH after 65535 en_dp pulses; undefined -> no SWITCH.

Source files
------------

// File: rtl/led_sequencer.sv
// LED pattern sequencer: steps the datapath at a programmable rate and rotates the display mode
// after a set number of completed passes. Define LED_SEQ_TIMEOUT_EN to add a step watchdog.
module led_sequencer #(
    parameter int unsigned BASE_DIV = 25000000,
    parameter int unsigned PASSES   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  speed,
    input  logic [26:0] feedback,
    output logic [1:0]  mode_out,
    output logic        en_dp,
    output logic        dp_rst,
    output logic        busy
);

    localparam logic [26:0] HomePattern = 27'h0000038;
    localparam logic [26:0] BaseDiv     = 27'(BASE_DIV);
    localparam logic [3:0]  Passes      = 4'(PASSES);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StSwitch
    } state_e;

    state_e      state_q;
    logic [26:0] div_q;
    logic [26:0] div_lim_q;
    logic [3:0]  pass_q;
    logic        away_q;
    logic        chk_q;

    logic        home_hit;
    logic        pass_done;
    logic        pass_last;
    logic        div_wrap;
    logic        timeout;
    logic        go_switch;

    function automatic logic [26:0] divisor(input logic [1:0] spd);
        logic [26:0] d;
        d = BaseDiv >> spd;
        return (d == 27'd0) ? 27'd1 : d;
    endfunction

    function automatic logic [1:0] next_mode(input logic [1:0] m);
        logic [1:0] n;
        unique case (m)
            2'b01:   n = 2'b10;
            2'b10:   n = 2'b11;
            default: n = 2'b01;
        endcase
        return n;
    endfunction

    // chk_q marks the cycle after a step pulse, when feedback reflects the new pattern.
    assign home_hit  = (feedback == HomePattern);
    assign pass_done = (state_q == StRun) && chk_q && home_hit && away_q;
    assign pass_last = pass_done && ((pass_q + 4'd1) == Passes);
    assign div_wrap  = (state_q == StRun) && (div_q == div_lim_q - 27'd1);

`ifdef LED_SEQ_TIMEOUT_EN
    logic [15:0] wd_q;
    assign timeout = (state_q == StRun) && en_dp && (wd_q == 16'hFFFE);
`else
    assign timeout = 1'b0;
`endif

    assign go_switch = pass_last || timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mode_out  <= 2'b01;
            en_dp     <= 1'b0;
            dp_rst    <= 1'b0;
            busy      <= 1'b0;
            div_q     <= '0;
            div_lim_q <= divisor(2'd0);
            pass_q    <= '0;
            away_q    <= 1'b0;
            chk_q     <= 1'b0;
`ifdef LED_SEQ_TIMEOUT_EN
            wd_q      <= '0;
`endif
        end else begin
            en_dp  <= 1'b0;
            dp_rst <= 1'b0;
            chk_q  <= 1'b0;
            if (!en) begin
                // Pausing discards any pass completing this cycle; mode is kept.
                state_q <= StIdle;
                busy    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q <= StLoad;
                        dp_rst  <= 1'b1;
                        busy    <= 1'b1;
                        div_q   <= '0;
                        pass_q  <= '0;
                        away_q  <= 1'b0;
`ifdef LED_SEQ_TIMEOUT_EN
                        wd_q    <= '0;
`endif
                    end
                    StLoad: begin
                        state_q   <= StRun;
                        div_q     <= '0;
                        div_lim_q <= divisor(speed);
                        pass_q    <= '0;
                        away_q    <= 1'b0;
`ifdef LED_SEQ_TIMEOUT_EN
                        wd_q      <= '0;
`endif
                    end
                    StRun: begin
                        if (go_switch) begin
                            state_q  <= StSwitch;
                            mode_out <= next_mode(mode_out);
                            dp_rst   <= 1'b1;
                            div_q    <= '0;
                            pass_q   <= '0;
                            away_q   <= 1'b0;
`ifdef LED_SEQ_TIMEOUT_EN
                            wd_q     <= '0;
`endif
                        end else begin
                            if (div_wrap) begin
                                div_q     <= '0;
                                en_dp     <= 1'b1;
                                div_lim_q <= divisor(speed);
                            end else begin
                                div_q <= div_q + 27'd1;
                            end
                            chk_q <= en_dp;
                            if (pass_done) begin
                                pass_q <= pass_q + 4'd1;
                                away_q <= 1'b0;
                            end else if (chk_q && !home_hit) begin
                                away_q <= 1'b1;
                            end
`ifdef LED_SEQ_TIMEOUT_EN
                            if (pass_done) begin
                                wd_q <= '0;
                            end else if (en_dp) begin
                                wd_q <= wd_q + 16'd1;
                            end
`endif
                        end
                    end
                    StSwitch: begin
                        state_q   <= StRun;
                        div_q     <= '0;
                        div_lim_q <= divisor(speed);
                    end
                endcase
            end
        end
    end

endmodule
